// File: rtl/glyph_scaler_pkg.sv
// Shared definitions for the glyph address path: geometry defaults,
// width helpers, scale saturation and the glyph index record consumed by
// the font ROM and character buffer.
package glyph_pkg;

    localparam int CHARA_WIDTH_DEF  = 8;
    localparam int CHARA_HEIGHT_DEF = 11;
    localparam int MAX_SCALE_DEF    = 15;
    localparam int COLW_DEF         = 7;
    localparam int ROWW_DEF         = 6;

    // Width of a scale factor able to hold 0..max_scale.
    function automatic int scale_w(input int max_scale);
        return $clog2(max_scale + 1);
    endfunction

    // Width of the pixel-column index inside a glyph.
    function automatic int bit_w(input int chara_width);
        return $clog2(chara_width);
    endfunction

    // Width of the glyph line index.
    function automatic int line_w(input int chara_height);
        return $clog2(chara_height);
    endfunction

    // A scale of 0 means "unscaled"; anything beyond the limit is clamped.
    function automatic int sat_scale(input int value, input int max_scale);
        if (value == 0) begin
            return 1;
        end
        if (value > max_scale) begin
            return max_scale;
        end
        return value;
    endfunction

    localparam int BIT_W_DEF  = bit_w(CHARA_WIDTH_DEF);
    localparam int LINE_W_DEF = line_w(CHARA_HEIGHT_DEF);

    // Glyph address as seen by the font ROM / character buffer.
    typedef struct packed {
        logic [BIT_W_DEF-1:0]  bit_cnt;
        logic [LINE_W_DEF-1:0] line_cnt;
        logic [COLW_DEF-1:0]   col;
        logic [ROWW_DEF-1:0]   row;
    } glyph_idx_t;

endpackage

// File: rtl/glyph_scaler_if.sv
// Bundle between the display timing side (master) and the glyph scaler
// (slave): de/frame_start/scale requests in, glyph indices out.
interface glyph_scaler_if
    import glyph_pkg::*;
#(
    parameter int CHARA_WIDTH  = CHARA_WIDTH_DEF,
    parameter int CHARA_HEIGHT = CHARA_HEIGHT_DEF,
    parameter int MAX_SCALE    = MAX_SCALE_DEF,
    parameter int COLW         = COLW_DEF,
    parameter int ROWW         = ROWW_DEF
) ();

    localparam int SW = scale_w(MAX_SCALE);
    localparam int BW = bit_w(CHARA_WIDTH);
    localparam int LW = line_w(CHARA_HEIGHT);

    logic          de;
    logic          frame_start;
    logic [SW-1:0] scale_x;
    logic [SW-1:0] scale_y;

    logic          glyph_valid;
    logic          new_glyph;
    logic [BW-1:0] bit_cnt;
    logic [LW-1:0] line_cnt;
    logic [COLW-1:0] col;
    logic [ROWW-1:0] row;

    modport master (
        output de, frame_start, scale_x, scale_y,
        input  glyph_valid, new_glyph, bit_cnt, line_cnt, col, row
    );

    modport slave (
        input  de, frame_start, scale_x, scale_y,
        output glyph_valid, new_glyph, bit_cnt, line_cnt, col, row
    );

endinterface

// File: rtl/scale_div_cnt.sv
// Prescaled three-level wrap counter: sub counts 0..scale-1, cell counts
// 0..CELLS-1 on each sub wrap, char counts freely on each cell wrap.
// clr_i forces the present position to zero; when adv_i is also high the
// zero position is the one being consumed, so the state steps from zero.
// REG_OUT=0 presents the position being consumed this cycle (combinational
// after clear); REG_OUT=1 presents the stored state.
module scale_div_cnt #(
    parameter int SW      = 4,
    parameter int CELLS   = 8,
    parameter int CW      = 3,
    parameter int CHW     = 7,
    parameter bit CHAR_EN = 1'b1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic           clk_pix,
    input  logic           rst,
    input  logic           clr_i,
    input  logic           adv_i,
    input  logic [SW-1:0]  scale_i,
    output logic [SW-1:0]  sub_o,
    output logic [CW-1:0]  cell_o,
    output logic [CHW-1:0] char_o
);

    logic [SW-1:0] sub_q, sub_d, sub_base;
    logic [CW-1:0] cell_q, cell_d, cell_base;
    logic          sub_wrap;
    logic          cell_wrap;

    assign sub_base  = clr_i ? '0 : sub_q;
    assign cell_base = clr_i ? '0 : cell_q;

    // sub+1 >= scale also covers a scale lowered while sub is already past it.
    assign sub_wrap  = ({1'b0, sub_base} + (SW+1)'(1)) >= {1'b0, scale_i};
    assign cell_wrap = sub_wrap && (cell_base == CW'(CELLS - 1));

    // Next sub/cell position from the present (possibly cleared) position.
    always_comb begin
        sub_d  = sub_base;
        cell_d = cell_base;
        if (adv_i) begin
            sub_d = sub_wrap ? '0 : sub_base + SW'(1);
            if (sub_wrap) begin
                cell_d = cell_wrap ? '0 : cell_base + CW'(1);
            end
        end
    end

    // Sub and cell state.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            sub_q  <= '0;
            cell_q <= '0;
        end else begin
            sub_q  <= sub_d;
            cell_q <= cell_d;
        end
    end

    assign sub_o  = REG_OUT ? sub_q  : sub_base;
    assign cell_o = REG_OUT ? cell_q : cell_base;

    generate
        if (CHAR_EN) begin : g_char
            logic [CHW-1:0] char_q, char_d, char_base;

            assign char_base = clr_i ? '0 : char_q;
            assign char_d    = (adv_i && cell_wrap) ? char_base + CHW'(1) : char_base;

            // Character counter wraps modulo 2^CHW.
            always_ff @(posedge clk_pix or posedge rst) begin
                if (rst) begin
                    char_q <= '0;
                end else begin
                    char_q <= char_d;
                end
            end

            assign char_o = REG_OUT ? char_q : char_base;
        end else begin : g_no_char
            assign char_o = '0;
        end
    endgenerate

endmodule

// File: rtl/glyph_scaler.sv
// Pixel-to-glyph address generator. Turns the de stream into registered
// bit/line/column/row indices for integer-scaled glyphs. The X chain runs on
// de and restarts on its rising edge; the Y chain steps on each de falling
// edge and restarts on frame_start, which also latches the scales.
// Optional feature macro: GLYPH_SCALER_ROWCOL_EN builds the col/row counters;
// without it col and row are tied to 0.
module glyph_scaler
    import glyph_pkg::*;
#(
    parameter int CHARA_WIDTH  = CHARA_WIDTH_DEF,
    parameter int CHARA_HEIGHT = CHARA_HEIGHT_DEF,
    parameter int MAX_SCALE    = MAX_SCALE_DEF,
    parameter int DEF_SCALE_X  = 8,
    parameter int DEF_SCALE_Y  = 8,
    parameter int COLW         = COLW_DEF,
    parameter int ROWW         = ROWW_DEF
) (
    input  logic         clk_pix,
    input  logic         rst,
    glyph_scaler_if.slave bus
);

    localparam int SW = scale_w(MAX_SCALE);
    localparam int BW = bit_w(CHARA_WIDTH);
    localparam int LW = line_w(CHARA_HEIGHT);

`ifdef GLYPH_SCALER_ROWCOL_EN
    localparam bit ROWCOL_EN = 1'b1;
`else
    localparam bit ROWCOL_EN = 1'b0;
`endif

    logic          de_d_q;
    logic [SW-1:0] sx_act_q, sx_act_d;
    logic [SW-1:0] sy_act_q, sy_act_d;

    logic          de_rise, de_fall;
    logic          y_adv;

    logic [SW-1:0]   x_sub, y_sub;
    logic [BW-1:0]   x_cell;
    logic [LW-1:0]   y_cell;
    logic [COLW-1:0] x_char;
    logic [ROWW-1:0] y_char;

    logic          glyph_valid_q;
    logic          new_glyph_q;
    logic [BW-1:0] bit_q;

    // The Y chain never needs its sub position outside the counter.
    logic unused_y_sub;
    assign unused_y_sub = ^y_sub;

    assign de_rise = bus.de & ~de_d_q;
    assign de_fall = ~bus.de & de_d_q;
    // frame_start wins over a coincident falling edge so the Y chain stays cleared.
    assign y_adv   = de_fall & ~bus.frame_start;

    // Scale requests only take effect at frame boundaries.
    always_comb begin
        sx_act_d = sx_act_q;
        sy_act_d = sy_act_q;
        if (bus.frame_start) begin
            sx_act_d = SW'(sat_scale(int'(bus.scale_x), MAX_SCALE));
            sy_act_d = SW'(sat_scale(int'(bus.scale_y), MAX_SCALE));
        end
    end

    // Effective scales and de history.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            sx_act_q <= SW'(sat_scale(DEF_SCALE_X, MAX_SCALE));
            sy_act_q <= SW'(sat_scale(DEF_SCALE_Y, MAX_SCALE));
            de_d_q   <= 1'b0;
        end else begin
            sx_act_q <= sx_act_d;
            sy_act_q <= sy_act_d;
            de_d_q   <= bus.de;
        end
    end

    scale_div_cnt #(
        .SW      (SW),
        .CELLS   (CHARA_WIDTH),
        .CW      (BW),
        .CHW     (COLW),
        .CHAR_EN (ROWCOL_EN),
        .REG_OUT (1'b0)
    ) u_x_chain (
        .clk_pix (clk_pix),
        .rst     (rst),
        .clr_i   (de_rise),
        .adv_i   (bus.de),
        .scale_i (sx_act_q),
        .sub_o   (x_sub),
        .cell_o  (x_cell),
        .char_o  (x_char)
    );

    scale_div_cnt #(
        .SW      (SW),
        .CELLS   (CHARA_HEIGHT),
        .CW      (LW),
        .CHW     (ROWW),
        .CHAR_EN (ROWCOL_EN),
        .REG_OUT (1'b1)
    ) u_y_chain (
        .clk_pix (clk_pix),
        .rst     (rst),
        .clr_i   (bus.frame_start),
        .adv_i   (y_adv),
        .scale_i (sy_act_q),
        .sub_o   (y_sub),
        .cell_o  (y_cell),
        .char_o  (y_char)
    );

    // Present the consumed pixel one cycle later; blanked pixels read as zero.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            glyph_valid_q <= 1'b0;
            new_glyph_q   <= 1'b0;
            bit_q         <= '0;
        end else begin
            glyph_valid_q <= bus.de;
            new_glyph_q   <= bus.de && (x_sub == '0) && (x_cell == '0);
            bit_q         <= bus.de ? x_cell : '0;
        end
    end

    assign bus.glyph_valid = glyph_valid_q;
    assign bus.new_glyph   = new_glyph_q;
    assign bus.bit_cnt     = bit_q;
    assign bus.line_cnt    = y_cell;

`ifdef GLYPH_SCALER_ROWCOL_EN
    logic [COLW-1:0] col_q;

    // Column of the presented pixel; zero while blanked.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            col_q <= '0;
        end else begin
            col_q <= bus.de ? x_char : '0;
        end
    end

    assign bus.col = col_q;
    assign bus.row = y_char;
`else
    logic unused_char;
    assign unused_char = ^{x_char, y_char};

    assign bus.col = '0;
    assign bus.row = '0;
`endif

endmodule

// File: tb/tb_glyph_scaler.sv
// Directed bench for glyph_scaler: reset state, default scale, run-time
// scales, mid-frame scale requests, saturation, frame_start on a falling
// edge and reset in the middle of a line. MAX_SCALE is set to 12 so that
// an input of 15 exercises saturation.
module tb_glyph_scaler;
    import glyph_pkg::*;

    localparam int MAX_S = 12;
    localparam int SW    = $clog2(MAX_S + 1);

    logic clk_pix = 1'b0;
    logic rst     = 1'b1;

    int n_cmp = 0;
    int n_mis = 0;

    // Model state: effective scales and lines since the last frame_start.
    int sx_m;
    int sy_m;
    int nline;

    always #5 clk_pix = ~clk_pix;

    glyph_scaler_if #(.MAX_SCALE(MAX_S)) bus ();

    glyph_scaler #(.MAX_SCALE(MAX_S)) dut (
        .clk_pix (clk_pix),
        .rst     (rst),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // col/row only count when the feature is built in.
    function automatic int rc(input int v);
`ifdef GLYPH_SCALER_ROWCOL_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"},     bus.glyph_valid, 0);
        check({tag, ".new_glyph"}, bus.new_glyph,   0);
        check({tag, ".bit_cnt"},   bus.bit_cnt,     0);
        check({tag, ".line_cnt"},  bus.line_cnt,    0);
        check({tag, ".col"},       bus.col,         0);
        check({tag, ".row"},       bus.row,         0);
    endtask

    task automatic frame(input logic [SW-1:0] sx_in, input logic [SW-1:0] sy_in,
                         input int sx_eff, input int sy_eff);
        bus.scale_x     = sx_in;
        bus.scale_y     = sy_in;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        sx_m  = sx_eff;
        sy_m  = sy_eff;
        nline = 0;
        check("fs.line_cnt", bus.line_cnt, 0);
        check("fs.row",      bus.row,      0);
        $display("frame_start scale_x=%0d scale_y=%0d -> effective %0d/%0d", sx_in, sy_in, sx_eff, sy_eff);
    endtask

    // One active line of len pixels followed by a short blank; optionally
    // raises frame_start on the falling-edge cycle.
    task automatic run_line(input int len, input bit fs_end);
        int exp_line;
        int exp_row;
        exp_line = (nline / sy_m) % 11;
        exp_row  = rc((nline / (11 * sy_m)) % 64);
        bus.de = 1'b1;
        for (int p = 0; p < len; p++) begin
            step();
            check("px.valid",     bus.glyph_valid, 1);
            check("px.new_glyph", bus.new_glyph,   32'((p % (8 * sx_m)) == 0));
            check("px.bit_cnt",   bus.bit_cnt,     (p / sx_m) % 8);
            check("px.col",       bus.col,         rc((p / (8 * sx_m)) % 128));
            check("px.line_cnt",  bus.line_cnt,    exp_line);
            check("px.row",       bus.row,         exp_row);
        end
        bus.de = 1'b0;
        if (fs_end) begin
            bus.frame_start = 1'b1;
        end
        step();
        bus.frame_start = 1'b0;
        nline = fs_end ? 0 : nline + 1;
        check("blank.valid",     bus.glyph_valid, 0);
        check("blank.new_glyph", bus.new_glyph,   0);
        check("blank.bit_cnt",   bus.bit_cnt,     0);
        check("blank.line_cnt",  bus.line_cnt,    (nline / sy_m) % 11);
        check("blank.row",       bus.row,         rc((nline / (11 * sy_m)) % 64));
        repeat (3) step();
        $display("line len=%0d sx=%0d sy=%0d fs=%0d -> line_cnt=%0d row=%0d",
                 len, sx_m, sy_m, fs_end, bus.line_cnt, bus.row);
    endtask

    initial begin
        bus.de          = 1'b0;
        bus.frame_start = 1'b0;
        bus.scale_x     = SW'(8);
        bus.scale_y     = SW'(8);
        sx_m  = 8;
        sy_m  = 8;
        nline = 0;

        // Reset state
        repeat (2) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("post_reset");

        // 1: default scale 8, one 128-pixel line
        run_line(128, 1'b0);

        // 2: scale 2/3, 33 lines of 64 pixels -> line wraps to 0, row 1
        frame(SW'(2), SW'(3), 2, 3);
        for (int l = 0; l < 33; l++) begin
            run_line(64, 1'b0);
        end
        check("wrap.line_cnt", bus.line_cnt, 0);
        check("wrap.row",      bus.row,      rc(1));

        // 3: scale_x request mid-frame is ignored until frame_start
        bus.scale_x = SW'(4);
        run_line(32, 1'b0);
        frame(SW'(4), SW'(3), 4, 3);
        run_line(64, 1'b0);

        // 4: saturation of 0 -> 1 and 15 -> 12
        frame(SW'(0), SW'(1), 1, 1);
        run_line(20, 1'b0);
        frame(SW'(15), SW'(1), 12, 1);
        run_line(100, 1'b0);

        // 5: frame_start coincident with a de falling edge
        frame(SW'(2), SW'(1), 2, 1);
        run_line(16, 1'b0);
        run_line(16, 1'b0);
        check("pre_fs.line_cnt", bus.line_cnt, 2);
        run_line(16, 1'b1);
        run_line(16, 1'b0);

        // 6: reset pulsed at pixel 37 of a line
        bus.de = 1'b1;
        repeat (37) step();
        rst = 1'b1;
        step();
        check_all_zero("mid_reset");
        rst = 1'b0;
        bus.de = 1'b0;
        repeat (3) step();
        sx_m  = 8;
        sy_m  = 8;
        nline = 0;
        run_line(70, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/glyph_scaler.md
# glyph_scaler

Pixel-to-glyph address generator for the text-mode display path, and the successor to the fixed-scale magnifier. It sits between the display timing generator and the font ROM / character buffer. It turns the `de` stream into registered bit, line, column and row indices for integer-scaled glyphs. Scale factors are set per axis, selected at run time and latched at frame boundaries. Counting is driven by `de` edges rather than coordinate modulo, so it works with any blanking or porch.

## Interface
Parameters:
- `CHARA_WIDTH`, default 8: glyph width in pixels.
- `CHARA_HEIGHT`, default 11: glyph height in lines.
- `MAX_SCALE`, default 15: largest accepted scale factor.
- `DEF_SCALE_X`, default 8: horizontal scale loaded at reset.
- `DEF_SCALE_Y`, default 8: vertical scale loaded at reset.
- `COLW`, default 7: width of the column counter.
- `ROWW`, default 6: width of the row counter.

Ports (clock and reset first):
- `clk_pix` in 1: pixel clock. This is the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `de` in 1: active-video enable.
- `frame_start` in 1: one-cycle pulse, issued once per frame during vertical blanking.
- `scale_x` in SW: requested horizontal scale. SW = $clog2(MAX_SCALE+1).
- `scale_y` in SW: requested vertical scale.
- `glyph_valid` out 1: the index outputs describe an active pixel.
- `new_glyph` out 1: pulse on the first pixel of each glyph cell.
- `bit_cnt` out $clog2(CHARA_WIDTH): pixel column inside the glyph.
- `line_cnt` out $clog2(CHARA_HEIGHT): glyph line.
- `col` out COLW: character column.
- `row` out ROWW: character row.

## Operation
Scale handling:
- Effective scale registers `sx_act` and `sy_act` hold the scale in use.
- They are loaded from `DEF_SCALE_X` and `DEF_SCALE_Y` on reset.
- They are loaded from `scale_x` and `scale_y` on each `frame_start`.
- Inputs of 0 load 1. Inputs above MAX_SCALE load MAX_SCALE.
- A scale change between frame_start pulses has no effect.

X chain (advances on every cycle with `de`=1):
- `sub_x` counts 0..sx_act-1 and wraps.
- When `sub_x` wraps, `bit` advances 0..CHARA_WIDTH-1 and wraps.
- When `bit` wraps, `col` advances and wraps modulo 2^COLW.
- `de` rising edge (de=1 and de_d=0, with de_d the registered `de`): the current pixel is sub_x=0, bit=0, col=0, regardless of prior state.

Y chain (advances once per line):
- It advances on the `de` falling edge (de=0 and de_d=1).
- `sub_y` counts 0..sy_act-1 and wraps.
- When `sub_y` wraps, `line` advances 0..CHARA_HEIGHT-1 and wraps.
- When `line` wraps, `row` advances and wraps modulo 2^ROWW.

`frame_start` behaviour:
- Clears sub_y, line and row, and latches the scale.
- Takes priority over a simultaneous `de` falling edge. The Y chain stays cleared.
- If asserted while de=1, the X chain continues counting and only the Y chain and scale are affected.

Outputs:
- `new_glyph` = glyph_valid & (sub_x==0) & (bit==0) for the presented pixel.

## Timing
- All outputs are registered. Latency is 1 cycle.
- For a cycle N with de=1, cycle N+1 presents that pixel's bit_cnt and col, with glyph_valid=1.
- For a cycle with de=0, the next cycle has glyph_valid=0, new_glyph=0 and bit_cnt=0.
- `line_cnt` and `row` update on the cycle after the de falling edge. They hold through the whole of the next active line.
- A scale latched by `frame_start` takes effect from the first de rising edge after it.
- Reset values are 0 for glyph_valid, new_glyph, bit_cnt, line_cnt, col, row and de_d. Reset also clears all internal counters.
- Reset mid-line: outputs are 0 immediately. Counting restarts at the next de rising edge.

## Configuration
Macro `GLYPH_SCALER_ROWCOL_EN`:
- Defined: the `col` and `row` counters are built and drive their outputs.
- Undefined: the counters are removed, `col` and `row` are tied to 0, and `new_glyph` still operates.

## Structure
Shared package `glyph_pkg`:
- Holds the CHARA_WIDTH and CHARA_HEIGHT defaults.
- Holds the SW, bit-width and line-width localparam helpers.
- Holds a `glyph_idx_t` struct {bit, line, col, row} used by the font-ROM and character-buffer consumers.

Sub-module:
- One generic sub-module, `scale_div_cnt`, instanced twice (X chain and Y chain).
- It is a prescaler with a synchronous clear and an advance enable.
- It has three cascaded wrap counters: sub, cell and char.

## Test plan
1. Reset, default scale 8, de high for 128 cycles: bit_cnt steps every 8 cycles 0..7 and wraps. col=1 at output cycle 65. new_glyph pulses at cycles 1, 65.
2. frame_start with scale_x=2, scale_y=3, then lines of 64 de cycles: bit_cnt changes every 2 cycles. line_cnt increments after every 3rd line and wraps 10→0 after 33 lines, with row=1.
3. scale_x changes to 4 mid-frame: there is no effect until the next frame_start. Afterwards the period is 4.
4. scale_x=0 and scale_x=MAX_SCALE+? (saturating input, e.g. 15 with MAX_SCALE=12) at frame_start: the effective scales are 1 and 12 respectively.
5. frame_start coincident with a de falling edge: line_cnt=0, row=0 on the following line, with no increment.
6. rst pulsed at pixel 37 of a line: all outputs are 0 on the next cycle. The next line starts at bit_cnt=0, col=0.
